// File: rtl/hp_add.sv
// rtl/hp_add.sv - pipelined IEEE-754 adder/subtractor (bfloat16 by default), one-cycle latency
module hp_add #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NEXP+NSIG:0]   a,
  input  logic [NEXP+NSIG:0]   b,
  input  logic                 operation,
  output logic [NEXP+NSIG:0]   s,
  output logic [5:0]           bfFlags,
  output logic [4:0]           exception
);

  localparam int W  = NEXP + NSIG + 1;
  localparam int M  = NSIG + 4;   // hidden bit, fraction, guard, round, sticky
  localparam int EW = NEXP + 2;
  localparam logic [NEXP-1:0] EMAX = '1;

  logic            sa, sb;
  logic [NEXP-1:0] ea, eb;
  logic [NSIG-1:0] fa, fb;
  logic            a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;

  assign sa = a[W-1];
  assign sb = b[W-1] ^ operation;
  assign ea = a[W-2:NSIG];
  assign eb = b[W-2:NSIG];
  assign fa = a[NSIG-1:0];
  assign fb = b[NSIG-1:0];

  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_snan = a_nan & ~fa[NSIG-1];
  assign b_snan = b_nan & ~fb[NSIG-1];
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);

  logic            sx, sy;
  logic [NEXP-1:0] ex, ey, exx, eyy, d;
  logic [NSIG-1:0] fx, fy;
  logic [M-1:0]    xext, yext, yal;
  logic [M:0]      sum;
  logic [M-1:0]    nrm;
  logic [EW-1:0]   er0, er1, er2, fexp;
  logic [NSIG+1:0] rnd;
  logic [NSIG-1:0] frac;
  logic            hid2, g, r, st, inc, inexact, tiny, ovf, is_zero, zsign;
  int              lz, lim, shi;
  logic [W-1:0]    res;
  logic [4:0]      exc;
  logic [5:0]      cls;

  always_comb begin
    // order operands so x has the larger magnitude
    if ({ea, fa} >= {eb, fb}) begin
      sx = sa; ex = ea; fx = fa; sy = sb; ey = eb; fy = fb;
    end else begin
      sx = sb; ex = eb; fx = fb; sy = sa; ey = ea; fy = fa;
    end
    exx  = (ex == '0) ? NEXP'(1) : ex;
    eyy  = (ey == '0) ? NEXP'(1) : ey;
    d    = exx - eyy;
    xext = {(ex != '0), fx, 3'b000};
    yext = {(ey != '0), fy, 3'b000};

    if (32'(d) >= 32'(M)) begin
      yal    = '0;
      yal[0] = |yext;
    end else begin
      yal    = yext >> d;
      yal[0] = yal[0] | (|(yext & ~({M{1'b1}} << d)));
    end

    if (sx ^ sy) sum = {1'b0, xext} - {1'b0, yal};
    else         sum = {1'b0, xext} + {1'b0, yal};

    er0 = {2'b00, exx};
    lz  = M;
    for (int i = 0; i < M; i++)
      if (sum[i]) lz = M - 1 - i;
    lim = int'(er0) - 1;
    shi = 0;
    if (sum[M]) begin
      nrm    = sum[M:1];
      nrm[0] = sum[1] | sum[0];
      er1    = er0 + EW'(1);
    end else begin
      // left shift stops at the minimum exponent, leaving a subnormal
      shi = (lz < lim) ? lz : lim;
      nrm = sum[M-1:0] << shi;
      er1 = er0 - EW'(shi);
    end

    g       = nrm[2];
    r       = nrm[1];
    st      = nrm[0];
    inc     = g & (r | st | nrm[3]);
    inexact = g | r | st;
    tiny    = ~nrm[M-1];
    rnd     = {1'b0, nrm[M-1:3]} + (NSIG+2)'(inc);
    if (rnd[NSIG+1]) begin
      er2  = er1 + EW'(1);
      hid2 = 1'b1;
      frac = rnd[NSIG:1];
    end else begin
      er2  = er1;
      hid2 = rnd[NSIG];
      frac = rnd[NSIG-1:0];
    end
    fexp    = hid2 ? er2 : '0;
    ovf     = fexp >= {2'b00, EMAX};
    is_zero = (sum == '0);
    zsign   = (sx == sy) ? sx : 1'b0;

    res = {sx, fexp[NEXP-1:0], frac};
    exc = {inexact, tiny & inexact, 3'b000};
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      res = {1'b0, EMAX, 1'b1, {(NSIG-1){1'b0}}};
      exc = {4'b0000, a_snan | b_snan | (a_inf & b_inf)};
    end else if (a_inf) begin
      res = {sa, EMAX, {NSIG{1'b0}}};
      exc = '0;
    end else if (b_inf) begin
      res = {sb, EMAX, {NSIG{1'b0}}};
      exc = '0;
    end else if (is_zero) begin
      res = {zsign, {(W-1){1'b0}}};
      exc = '0;
    end else if (ovf) begin
      res = {sx, EMAX, {NSIG{1'b0}}};
      exc = 5'b10100;
    end

    // one-hot class of the final result
    cls = 6'b000001;
    if (&res[W-2:NSIG]) begin
      if (res[NSIG-1:0] == '0)  cls = 6'b001000;
      else if (res[NSIG-1])     cls = 6'b010000;
      else                      cls = 6'b100000;
    end else if (res[W-2:NSIG] == '0) begin
      cls = (res[NSIG-1:0] == '0) ? 6'b000100 : 6'b000010;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      bfFlags   <= 6'b000100;
      exception <= '0;
    end else begin
      s         <= res;
      bfFlags   <= cls;
      exception <= exc;
    end
  end

endmodule

// File: tb/tb_hp_add.sv
// tb/tb_hp_add.sv - directed self-checking bench for hp_add
module tb_hp_add;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        operation = 1'b0;
  logic [15:0] s;
  logic [5:0]  bfFlags;
  logic [4:0]  exception;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] NRM = 6'b000001, SUB = 6'b000010, ZER = 6'b000100,
                         INF = 6'b001000, QNN = 6'b010000;

  hp_add #(.NEXP(8), .NSIG(7)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .operation(operation),
    .s(s), .bfFlags(bfFlags), .exception(exception)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vop, input logic [15:0] es, input logic [5:0] ef,
                         input logic [4:0] ee);
    @(negedge clk);
    a = va; b = vb; operation = vop;
    @(posedge clk);
    #1;
    chk({tag, ".s"}, s, es);
    chk({tag, ".flags"}, {10'd0, bfFlags}, {10'd0, ef});
    chk({tag, ".exc"}, {11'd0, exception}, {11'd0, ee});
  endtask

  initial begin
    #12;
    chk("rst.s", s, 16'h0000);
    chk("rst.flags", {10'd0, bfFlags}, {10'd0, ZER});
    chk("rst.exc", {11'd0, exception}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_vec("1p2",      16'h3F80, 16'h4000, 1'b0, 16'h4040, NRM, 5'b00000);
    run_vec("1m1",      16'h3F80, 16'h3F80, 1'b1, 16'h0000, ZER, 5'b00000);
    run_vec("n1p1",     16'hBF80, 16'h3F80, 1'b0, 16'h0000, ZER, 5'b00000);
    run_vec("infminf",  16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, QNN, 5'b00001);
    run_vec("infmninf", 16'h7F80, 16'hFF80, 1'b1, 16'h7F80, INF, 5'b00000);
    run_vec("ovf",      16'h7F00, 16'h7F00, 1'b0, 16'h7F80, INF, 5'b10100);
    run_vec("ovfmax",   16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, INF, 5'b10100);
    run_vec("subn",     16'h0001, 16'h0001, 1'b0, 16'h0002, SUB, 5'b00000);
    run_vec("sub2norm", 16'h007F, 16'h0001, 1'b0, 16'h0080, NRM, 5'b00000);
    run_vec("tieeven",  16'h3F80, 16'h3B80, 1'b0, 16'h3F80, NRM, 5'b10000);
    run_vec("tieup",    16'h3F81, 16'h3B80, 1'b0, 16'h3F82, NRM, 5'b10000);
    run_vec("rndup",    16'h3F80, 16'h3BC0, 1'b0, 16'h3F81, NRM, 5'b10000);
    run_vec("sticky",   16'h3F80, 16'h0001, 1'b0, 16'h3F80, NRM, 5'b10000);
    run_vec("cancel",   16'h3F81, 16'h3F80, 1'b1, 16'h3C00, NRM, 5'b00000);
    run_vec("3m1",      16'h4040, 16'h3F80, 1'b1, 16'h4000, NRM, 5'b00000);
    run_vec("n1p2",     16'hBF80, 16'h4000, 1'b0, 16'h3F80, NRM, 5'b00000);
    run_vec("nz_nz",    16'h8000, 16'h8000, 1'b0, 16'h8000, ZER, 5'b00000);
    run_vec("pz_nz",    16'h0000, 16'h8000, 1'b0, 16'h0000, ZER, 5'b00000);
    run_vec("qnan",     16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, QNN, 5'b00000);
    run_vec("snan",     16'h7F81, 16'h3F80, 1'b0, 16'h7FC0, QNN, 5'b00001);
    run_vec("ninfmfin", 16'hFF80, 16'h3F80, 1'b1, 16'hFF80, INF, 5'b00000);

    // asynchronous reset between edges, with a non-zero result in the register
    run_vec("pre_rst",  16'h3F80, 16'h4000, 1'b0, 16'h4040, NRM, 5'b00000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.s", s, 16'h0000);
    chk("midrst.flags", {10'd0, bfFlags}, {10'd0, ZER});
    chk("midrst.exc", {11'd0, exception}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("infp1",    16'h7F80, 16'h3F80, 1'b0, 16'h7F80, INF, 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
